// File: rtl/dht11_frame_decoder.sv
// rtl/dht11_frame_decoder.sv - DHT11 frame checksum decoder with handshake, error counter and watchdog (option: DHT11_RANGE_CHECK_EN)
module dht11_frame_decoder #(
    parameter logic [20:0] WDOG_LIMIT = 21'd1999999
) (
    input  logic        clock_1M,
    input  logic        reset,
    input  logic [39:0] frame_in,
    input  logic        frame_done,
    input  logic        frame_erro,
    input  logic        out_ready,
    output logic [7:0]  umidade_int,
    output logic [7:0]  umidade_dec,
    output logic [7:0]  temperatura_int,
    output logic [7:0]  temperatura_dec,
    output logic        out_valid,
    output logic        erro_checksum,
    output logic [7:0]  contador_erros,
    output logic        overrun,
    output logic        dado_antigo
);

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic [39:0] frame_q;
    logic        erro_q;
    logic [20:0] wdog;
    logic [7:0]  checksum_sum;
    logic        checksum_ok;
    logic        frame_ok;
    logic        erro_rise;
    logic        latch_frame;
    logic        count_err;
    logic        accept;
    logic        reject;
    logic        release_sample;
    logic        set_overrun;

    // 8-bit wrap-around sum of the four data bytes against the trailing checksum byte
    assign checksum_sum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign checksum_ok  = (checksum_sum == frame_q[7:0]);
    assign erro_rise    = frame_erro & ~erro_q;

`ifdef DHT11_RANGE_CHECK_EN
    logic range_ok;
    // Physically implausible readings are treated exactly like a corrupted frame
    assign range_ok = (frame_q[39:32] >= 8'd20) && (frame_q[39:32] <= 8'd90) &&
                      (frame_q[23:16] <= 8'd50);
    assign frame_ok = checksum_ok & range_ok;
`else
    assign frame_ok = checksum_ok;
`endif

    // State register
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_next     = state;
        latch_frame    = 1'b0;
        count_err      = 1'b0;
        accept         = 1'b0;
        reject         = 1'b0;
        release_sample = 1'b0;
        set_overrun    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    if (frame_erro) begin
                        count_err = 1'b1;
                    end else begin
                        latch_frame = 1'b1;
                        state_next  = CHECK;
                    end
                end else if (erro_rise) begin
                    count_err = 1'b1;
                end
            end
            CHECK: begin
                set_overrun = frame_done;
                if (frame_ok) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end else begin
                    reject     = 1'b1;
                    count_err  = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                set_overrun = frame_done;
                if (out_ready) begin
                    release_sample = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame capture and acquisition-error edge history
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            frame_q <= 40'd0;
            erro_q  <= 1'b0;
        end else begin
            erro_q <= frame_erro;
            if (latch_frame) frame_q <= frame_in;
        end
    end

    // Decoded sample, handshake, error pulse, saturating counter and sticky overrun
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            umidade_int     <= 8'd0;
            umidade_dec     <= 8'd0;
            temperatura_int <= 8'd0;
            temperatura_dec <= 8'd0;
            out_valid       <= 1'b0;
            erro_checksum   <= 1'b0;
            contador_erros  <= 8'd0;
            overrun         <= 1'b0;
        end else begin
            erro_checksum <= reject;
            if (accept) begin
                umidade_int     <= frame_q[39:32];
                umidade_dec     <= frame_q[31:24];
                temperatura_int <= frame_q[23:16];
                temperatura_dec <= frame_q[15:8];
                out_valid       <= 1'b1;
            end else if (release_sample) begin
                out_valid <= 1'b0;
            end
            if (count_err && contador_erros != 8'hFF) contador_erros <= contador_erros + 8'd1;
            if (set_overrun) overrun <= 1'b1;
        end
    end

    // Staleness watchdog: restarts on every accepted frame, parks at the limit
    always_ff @(posedge clock_1M or negedge reset) begin
        if (!reset) begin
            wdog        <= 21'd0;
            dado_antigo <= 1'b0;
        end else if (accept) begin
            wdog        <= 21'd0;
            dado_antigo <= 1'b0;
        end else if (wdog == WDOG_LIMIT) begin
            dado_antigo <= 1'b1;
        end else begin
            wdog <= wdog + 21'd1;
        end
    end

endmodule

// File: tb/tb_dht11_frame_decoder.sv
// tb/tb_dht11_frame_decoder.sv - self-checking bench for dht11_frame_decoder
`timescale 1ns/1ps
module tb_dht11_frame_decoder;

    localparam logic [20:0] LIMIT = 21'd2000;

    logic        clock_1M = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] frame_in = 40'd0;
    logic        frame_done = 1'b0;
    logic        frame_erro = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  umidade_int, umidade_dec, temperatura_int, temperatura_dec;
    logic        out_valid, erro_checksum, overrun, dado_antigo;
    logic [7:0]  contador_erros;

    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    logic [31:0] sb[$];
    logic [31:0] last_fields = 32'd0;
    logic [7:0]  exp_cnt = 8'd0;

    dht11_frame_decoder #(.WDOG_LIMIT(LIMIT)) dut (
        .clock_1M(clock_1M), .reset(reset), .frame_in(frame_in),
        .frame_done(frame_done), .frame_erro(frame_erro), .out_ready(out_ready),
        .umidade_int(umidade_int), .umidade_dec(umidade_dec),
        .temperatura_int(temperatura_int), .temperatura_dec(temperatura_dec),
        .out_valid(out_valid), .erro_checksum(erro_checksum),
        .contador_erros(contador_erros), .overrun(overrun), .dado_antigo(dado_antigo)
    );

    always #500 clock_1M = ~clock_1M;

    function automatic logic [31:0] fields();
        return {umidade_int, umidade_dec, temperatura_int, temperatura_dec};
    endfunction

    function automatic logic model_ok(input logic [39:0] f);
        logic [7:0] s;
        logic       ok;
        s  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        ok = (s == f[7:0]);
`ifdef DHT11_RANGE_CHECK_EN
        if (f[39:32] > 8'd90 || f[39:32] < 8'd20 || f[23:16] > 8'd50) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_1M);
        #1;
    endtask

    // Drives one frame_done pulse and checks the CHECK-cycle outcome against the model
    task automatic do_frame(input logic [39:0] f, output logic ok);
        logic [31:0] e;
        ok = model_ok(f);
        if (ok) sb.push_back(f[39:8]);
        frame_in   = f;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("valid_low_in_check", out_valid, 1'b0);
        tick();
        if (ok) begin
            check("valid_latency", out_valid, 1'b1);
            check("no_erro_pulse", erro_checksum, 1'b0);
            check("sb_entry", sb.size(), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("fields", fields(), e);
                last_fields = e;
            end
        end else begin
            exp_cnt = sat_inc(exp_cnt);
            check("erro_pulse", erro_checksum, 1'b1);
            check("valid_stays_low", out_valid, 1'b0);
            check("cnt_after_reject", contador_erros, exp_cnt);
            check("fields_kept", fields(), last_fields);
            tick();
            check("erro_pulse_end", erro_checksum, 1'b0);
        end
    endtask

    task automatic release_sample();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
    endtask

    task automatic frame_and_release(input logic [39:0] f);
        logic ok;
        do_frame(f, ok);
        if (ok) release_sample();
    endtask

    initial begin
        logic ok;
        // Reset state
        tick();
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_fields", fields(), 32'd0);
        check("rst_cnt", contador_erros, 8'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_dado", dado_antigo, 1'b0);
        check("rst_erro", erro_checksum, 1'b0);
        @(negedge clock_1M) reset = 1'b1;

        // Basic accept, hold while not ready, then handshake
        do_frame(40'h3700190050, ok);
        tick();
        tick();
        check("hold_valid", out_valid, 1'b1);
        check("hold_fields", fields(), 32'h37001900);
        release_sample();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ready_ignored", out_valid, 1'b0);

        // Checksum mismatch and wrap-around / range cases
        frame_and_release(40'h3700190051);
        frame_and_release(40'hFF01FF01FF);
        frame_and_release(40'hFF01FF0100);
        frame_and_release(40'h5AFF32FF8A);

        // Overrun while sample pending
        check("overrun_clear", overrun, 1'b0);
        do_frame(40'h2A0B1C0556, ok);
        frame_in   = 40'h3700190050;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("overrun_set", overrun, 1'b1);
        check("overrun_valid", out_valid, 1'b1);
        check("overrun_fields", fields(), 32'h2A0B1C05);
        release_sample();
        check("overrun_sticky", overrun, 1'b1);

        // frame_done with frame_erro is discarded and counted once
        frame_erro = 1'b1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        frame_erro = 1'b0;
        exp_cnt = sat_inc(exp_cnt);
        check("erro_frame_cnt", contador_erros, exp_cnt);
        tick();
        check("erro_frame_no_valid", out_valid, 1'b0);

        // Acquisition-error edges saturate the counter
        for (int i = 0; i < 260; i++) begin
            frame_erro = 1'b1;
            tick();
            frame_erro = 1'b0;
            tick();
            exp_cnt = sat_inc(exp_cnt);
        end
        check("cnt_saturated", contador_erros, exp_cnt);
        check("cnt_is_255", exp_cnt, 8'hFF);

        // Reset in HOLD drops the sample immediately
        do_frame(40'h3700190050, ok);
        reset = 1'b0;
        #1;
        check("rst_hold_valid", out_valid, 1'b0);
        check("rst_hold_fields", fields(), 32'd0);
        check("rst_hold_cnt", contador_erros, 8'd0);
        check("rst_hold_overrun", overrun, 1'b0);
        exp_cnt = 8'd0;
        last_fields = 32'd0;
        @(negedge clock_1M) reset = 1'b1;
        frame_and_release(40'h3700190050);

        // Accept and new frame_done on the same HOLD edge
        do_frame(40'h2A0B1C0556, ok);
        frame_in   = 40'h3700190050;
        frame_done = 1'b1;
        out_ready  = 1'b1;
        tick();
        frame_done = 1'b0;
        out_ready  = 1'b0;
        check("accept_drop_valid", out_valid, 1'b0);
        check("accept_drop_overrun", overrun, 1'b1);
        tick();
        check("dropped_stays_idle", out_valid, 1'b0);

        // Watchdog staleness
        reset = 1'b0;
        #1;
        @(negedge clock_1M) reset = 1'b1;
        repeat (LIMIT) tick();
        check("dado_before_limit", dado_antigo, 1'b0);
        tick();
        check("dado_at_limit", dado_antigo, 1'b1);
        repeat (5) tick();
        check("dado_held", dado_antigo, 1'b1);
        do_frame(40'h3700190050, ok);
        check("dado_cleared", dado_antigo, 1'b0);
        release_sample();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
